// File: rtl/instr_imm_encoder.sv
// rtl/instr_imm_encoder.sv - packs an immediate into I/S/B/U/J instruction fields behind a 2-entry output FIFO
// Optional saturating error counter on err_count when IMMENC_ERR_CNT_EN is defined.
module instr_imm_encoder
`ifdef IMMENC_ERR_CNT_EN
    #(parameter int CNT_W = 16)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_template,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_immsrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
`ifdef IMMENC_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    logic [31:0] enc_instr;
    logic        enc_err;

    logic [31:0] entry_instr_q [2];
    logic [31:0] entry_instr_d [2];
    logic        entry_err_q   [2];
    logic        entry_err_d   [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        push, pop;

    // Fields are written from imm even when err is set, so a bad beat still truncates predictably.
    always_comb begin
        enc_instr = in_template;
        enc_err   = 1'b0;
        case (in_immsrc)
            3'b000: begin
                enc_instr[31:20] = in_imm[11:0];
                enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            3'b001: begin
                enc_instr[31:25] = in_imm[11:5];
                enc_instr[11:7]  = in_imm[4:0];
                enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            3'b010: begin
                enc_instr[31]    = in_imm[12];
                enc_instr[7]     = in_imm[11];
                enc_instr[30:25] = in_imm[10:5];
                enc_instr[11:8]  = in_imm[4:1];
                enc_err = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
            end
            3'b011: begin
                enc_instr[31:12] = in_imm[31:12];
                enc_err = |in_imm[11:0];
            end
            3'b100: begin
                enc_instr[31]    = in_imm[20];
                enc_instr[30:21] = in_imm[10:1];
                enc_instr[20]    = in_imm[11];
                enc_instr[19:12] = in_imm[19:12];
                enc_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
            end
            default: enc_err = 1'b1;
        endcase
    end

    // in_ready comes from registered count only, so a full buffer cannot push in the cycle it pops.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_instr = entry_instr_q[rd_ptr_q];
    assign out_err   = entry_err_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        entry_instr_d = entry_instr_q;
        entry_err_d   = entry_err_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (push) begin
            entry_instr_d[wr_ptr_q] = enc_instr;
            entry_err_d[wr_ptr_q]   = enc_err;
            wr_ptr_d                = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                entry_instr_q[i] <= 32'd0;
                entry_err_q[i]   <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry_instr_q <= entry_instr_d;
            entry_err_q   <= entry_err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

`ifdef IMMENC_ERR_CNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (push && enc_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_instr_imm_encoder.sv
// tb/tb_instr_imm_encoder.sv - randomized self-checking bench for instr_imm_encoder
module tb_instr_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_template;
    logic [31:0] in_imm;
    logic [2:0]  in_immsrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
`ifdef IMMENC_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [32:0] exp_q [$];
    int          model_err_cnt = 0;
    bit          last_accepted;

    instr_imm_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_template(in_template),
        .in_imm     (in_imm),
        .in_immsrc  (in_immsrc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err)
`ifdef IMMENC_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: range checks on the signed value plus mask/shift field placement.
    function automatic logic [32:0] model_encode(input logic [31:0] t, input logic [31:0] imm,
                                                 input logic [2:0] s);
        int signed   v;
        logic [31:0] m;
        logic [31:0] f;
        logic        e;
        v = $signed(imm);
        m = 32'd0;
        f = 32'd0;
        e = 1'b1;
        case (s)
            3'd0: begin
                m = 32'hFFF0_0000;
                f = (imm & 32'hFFF) << 20;
                e = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                m = 32'hFE00_0F80;
                f = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                e = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                m = 32'hFE00_0F80;
                f = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                    (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
                e = ((imm & 32'h1) != 0) || (v < -4096) || (v > 4095);
            end
            3'd3: begin
                m = 32'hFFFF_F000;
                f = imm & 32'hFFFF_F000;
                e = (imm & 32'hFFF) != 0;
            end
            3'd4: begin
                m = 32'hFFFF_F000;
                f = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                    (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000);
                e = ((imm & 32'h1) != 0) || (v < -1048576) || (v > 1048575);
            end
            default: begin
                m = 32'd0;
                f = 32'd0;
                e = 1'b1;
            end
        endcase
        return {e, (t & ~m) | f};
    endfunction

    // Advance one clock; model follows the handshake using its own occupancy, not DUT outputs.
    task automatic tick();
        bit          do_pop;
        bit          do_push;
        logic [32:0] enc;
        do_pop  = (exp_q.size() != 0) && out_ready;
        do_push = (exp_q.size() != 2) && in_valid;
        enc     = model_encode(in_template, in_imm, in_immsrc);
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            exp_q.push_back(enc);
            if (enc[32] && model_err_cnt != 65535) model_err_cnt++;
        end
        last_accepted = do_push;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        case ($urandom_range(0, 4))
            0: r = $urandom;
            1: r = int'($urandom_range(0, 4095)) - 2048;
            2: r = int'($urandom_range(0, 8191)) - 4096;
            3: r = int'($urandom_range(0, 2097151)) - 1048576;
            default: r = $urandom & 32'hFFFF_F000;
        endcase
        if ($urandom_range(0, 1) == 1) r = r & 32'hFFFF_FFFE;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", out_err); end
`ifdef IMMENC_ERR_CNT_EN
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
`endif
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_idle got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] t_tmpl [10] = '{32'h13, 32'h13, 32'h63, 32'h63, 32'h6F, 32'h6F, 32'h37, 32'h37,
                                     32'h23, 32'h6F};
        logic [31:0] t_imm  [10] = '{32'hFFFF_FFFF, 32'h800, 32'h800, 32'h2, 32'h1, 32'h1234,
                                     32'h1234_5000, 32'h1234_5001, 32'hFFFF_FFF8, 32'h800};
        logic [2:0]  t_src  [10] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd4, 3'd7, 3'd3, 3'd3, 3'd1, 3'd4};
        logic [31:0] t_exp  [10] = '{32'hFFF0_0013, 32'h8000_0013, 32'hE3, 32'h163, 32'h6F, 32'h6F,
                                     32'h1234_5037, 32'h1234_5037, 32'hFE00_0C23, 32'h0010_006F};
        logic        t_err  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int          start_err;
        start_err = model_err_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_template = t_tmpl[i];
            in_imm      = t_imm[i];
            in_immsrc   = t_src[i];
            in_valid    = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency out_valid got %b want 1", i, out_valid); end
            n_cmp++; if (out_instr !== t_exp[i] || out_err !== t_err[i]) begin
                n_fail++; $display("FAIL vec%0d_encode got %h/%b want %h/%b", i, out_instr, out_err, t_exp[i], t_err[i]);
            end
            n_cmp++; if (exp_q.size() == 0 || {out_err, out_instr} !== exp_q[0]) begin
                n_fail++; $display("FAIL vec%0d_model got %h/%b want model head", i, out_instr, out_err);
            end
            tick();
        end
        n_cmp++; if (model_err_cnt - start_err != 4) begin n_fail++; $display("FAIL vec_err_total got %0d want 4", model_err_cnt - start_err); end
`ifdef IMMENC_ERR_CNT_EN
        n_cmp++; if (err_count !== 16'(model_err_cnt)) begin n_fail++; $display("FAIL vec_err_count got %0d want %0d", err_count, model_err_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] beats [3];
        int          idx;
        int          got;
        for (int i = 0; i < 3; i++) beats[i] = $urandom & 32'hFFFF_F000;
        out_ready   = 1'b0;
        in_template = 32'h0000_0037;
        in_immsrc   = 3'd3;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_imm   = beats[idx];
            in_valid = 1'b1;
            tick();
            if (last_accepted && idx < 2) idx++;
        end
        n_cmp++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", idx); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== (beats[0] | 32'h37)) begin
            n_fail++; $display("FAIL bp_head_stable got %b/%h want 1/%h", out_valid, out_instr, beats[0] | 32'h37);
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            if (out_valid) begin
                n_cmp++; if (out_instr !== (beats[got] | 32'h37)) begin
                    n_fail++; $display("FAIL bp_order%0d got %h want %h", got, out_instr, beats[got] | 32'h37);
                end
                got++;
            end else begin
                n_cmp++; n_fail++; $display("FAIL bp_gap cycle %0d got out_valid 0 want 1", c);
            end
            tick();
            if (last_accepted) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_cmp++; if (got != 3) begin n_fail++; $display("FAIL bp_drain got %0d want 3", got); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() != 2)) begin
                n_fail++; $display("FAIL rand_flags cyc %0d got v=%b r=%b want size %0d", c, out_valid, in_ready, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                n_cmp++; if ({out_err, out_instr} !== exp_q[0]) begin
                    n_fail++; $display("FAIL rand_data cyc %0d got %b/%h want %b/%h", c, out_err, out_instr, exp_q[0][32], exp_q[0][31:0]);
                end
            end
`ifdef IMMENC_ERR_CNT_EN
            n_cmp++; if (err_count !== 16'(model_err_cnt)) begin
                n_fail++; $display("FAIL rand_err_count cyc %0d got %0d want %0d", c, err_count, model_err_cnt);
            end
`endif
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            in_template = $urandom;
            in_imm      = rand_imm();
            in_immsrc   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready   = 1'b0;
        in_template = 32'h13;
        in_immsrc   = 3'd0;
        in_imm      = 32'h0000_1000;
        in_valid    = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_fill got v=%b r=%b want v=1 r=0", out_valid, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_async got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        n_cmp++; if (out_instr !== 32'd0 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_data got %h/%b want 0/0", out_instr, out_err);
        end
`ifdef IMMENC_ERR_CNT_EN
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL midrst_err_count got %0d want 0", err_count); end
`endif
        exp_q.delete();
        model_err_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_after got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_template = 32'd0;
        in_imm      = 32'd0;
        in_immsrc   = 3'd0;
        out_ready   = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
